// File: rtl/gpu_operand_pkg.sv
// gpu_operand_pkg
//   Shared constants and types for the operand read path: the lane geometry of a
//   vector register, the identity swizzle code, FP32 field positions, the packed
//   lane-vector type and the swizzle helper used by operand_split.
package gpu_operand_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int VEC_W  = LANES * LANE_W;

  // Output lane k takes source lane k (3,2,1,0 packed two bits each).
  localparam logic [2*LANES-1:0] SWZ_IDENTITY = 8'hE4;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;

  // Lane 0 sits in the low 32 bits of the vector.
  typedef logic [LANES-1:0][LANE_W-1:0] lane_vec_t;

  // Output lane k = src[swz[2k+1:2k]].
  function automatic lane_vec_t swizzle_lanes(input lane_vec_t src,
                                              input logic [2*LANES-1:0] swz);
    lane_vec_t res;
    for (int k = 0; k < LANES; k++) begin
      res[k] = src[swz[2*k +: 2]];
    end
    return res;
  endfunction

endpackage

// File: rtl/operand_lane_mod.sv
// operand_lane_mod
//   Single-lane combinational source-modifier: optional flush-to-zero of
//   denormals, then abs (clear sign), then neg (invert sign). Only the sign bit
//   is touched by abs/neg; NaNs get the same sign handling as any other value.
//   Build option: OPERAND_SPLIT_FTZ_EN enables the denormal flush.
// Ports:
//   lane_i  FP32 operand after swizzle
//   abs_i   clear sign bit
//   neg_i   invert sign bit (after abs)
//   lane_o  modified operand
module operand_lane_mod
  import gpu_operand_pkg::*;
(
  input  logic [LANE_W-1:0] lane_i,
  input  logic              abs_i,
  input  logic              neg_i,
  output logic [LANE_W-1:0] lane_o
);

  logic [LANE_W-1:0] ftz_lane;

`ifdef OPERAND_SPLIT_FTZ_EN
  logic is_denorm;

  assign is_denorm = (lane_i[EXP_MSB:EXP_LSB] == '0) && (lane_i[EXP_LSB-1:0] != '0);
  // Denormal becomes a zero of the same sign.
  assign ftz_lane  = is_denorm ? {lane_i[SIGN_BIT], {SIGN_BIT{1'b0}}} : lane_i;
`else
  assign ftz_lane  = lane_i;
`endif

  always_comb begin
    lane_o           = ftz_lane;
    lane_o[SIGN_BIT] = (ftz_lane[SIGN_BIT] & ~abs_i) ^ neg_i;
  end

endmodule

// File: rtl/operand_split.sv
// operand_split
//   Read-side operand stage: splits a 128-bit register read into four FP32
//   lanes, applies the per-instruction swizzle and abs/neg modifiers, and hands
//   the lanes plus tag to execute through a one-deep output register backed by
//   a skid register (valid/ready on both sides, 1-cycle latency).
//   Build option: OPERAND_SPLIT_FTZ_EN flushes denormal lanes to signed zero.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous kill of all buffered operands
//   in_valid/in_ready   RF read handshake; in_ready depends only on skid state
//   in_data             128-bit register read, lane 0 = bits 31:0
//   in_swizzle          2-bit source select per output lane
//   in_abs, in_neg      sign modifiers applied to every lane
//   in_tag              instruction tag carried with the operands
//   out_valid/out_ready execute-side handshake
//   out_lane_0..3       processed lane operands
//   out_tag             tag of the presented operands
//
// Occupancy, encoded as {out_valid, skid_valid}:
//   state | meaning
//   EMPTY | 00: nothing buffered, input accepted into output register
//   ONE   | 10: output register holds operands, skid free
//   FULL  | 11: output stalled and skid holds the next operands, in_ready=0
module operand_split
  import gpu_operand_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_W-1:0]  in_data,
  input  logic [7:0]        in_swizzle,
  input  logic              in_abs,
  input  logic              in_neg,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_lane_0,
  output logic [LANE_W-1:0] out_lane_1,
  output logic [LANE_W-1:0] out_lane_2,
  output logic [LANE_W-1:0] out_lane_3,
  output logic [TAG_W-1:0]  out_tag
);

  lane_vec_t src_lanes;
  lane_vec_t swz_lanes;
  lane_vec_t mod_lanes;

  assign src_lanes = lane_vec_t'(in_data);
  assign swz_lanes = swizzle_lanes(src_lanes, in_swizzle);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    operand_lane_mod u_lane_mod (
      .lane_i (swz_lanes[k]),
      .abs_i  (in_abs),
      .neg_i  (in_neg),
      .lane_o (mod_lanes[k])
    );
  end

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  lane_vec_t        out_lanes_q, out_lanes_d;
  lane_vec_t        skid_lanes_q, skid_lanes_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic in_fire;
  logic out_fire;

  // in_ready comes only from a register so no ready path runs upstream.
  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_lanes_d  = out_lanes_q;
    out_tag_d    = out_tag_q;
    skid_lanes_d = skid_lanes_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      // Data registers keep their contents; only the valids are killed.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q) begin
      if (in_fire) begin
        out_valid_d = 1'b1;
        out_lanes_d = mod_lanes;
        out_tag_d   = in_tag;
      end
    end else if (!skid_valid_q) begin
      if (in_fire && out_fire) begin
        out_lanes_d = mod_lanes;
        out_tag_d   = in_tag;
      end else if (in_fire) begin
        skid_valid_d = 1'b1;
        skid_lanes_d = mod_lanes;
        skid_tag_d   = in_tag;
      end else if (out_fire) begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (out_fire) begin
        skid_valid_d = 1'b0;
        out_lanes_d  = skid_lanes_q;
        out_tag_d    = skid_tag_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_lanes_q  <= '0;
      out_tag_q    <= '0;
      skid_lanes_q <= '0;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_lanes_q  <= out_lanes_d;
      out_tag_q    <= out_tag_d;
      skid_lanes_q <= skid_lanes_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_lane_0 = out_lanes_q[0];
  assign out_lane_1 = out_lanes_q[1];
  assign out_lane_2 = out_lanes_q[2];
  assign out_lane_3 = out_lanes_q[3];
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_operand_split.sv
module tb_operand_split;
  import gpu_operand_pkg::*;

  localparam int TW = 6;
  localparam int EW = TW + 128;

  logic           clk;
  logic           rst;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   in_data;
  logic [7:0]     in_swizzle;
  logic           in_abs;
  logic           in_neg;
  logic [TW-1:0]  in_tag;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_lane_0, out_lane_1, out_lane_2, out_lane_3;
  logic [TW-1:0]  out_tag;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];

  operand_split #(.TAG_W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_swizzle (in_swizzle),
    .in_abs     (in_abs),
    .in_neg     (in_neg),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_lane_0 (out_lane_0),
    .out_lane_1 (out_lane_1),
    .out_lane_2 (out_lane_2),
    .out_lane_3 (out_lane_3),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference transform, written lane by lane with shifts and masks.
  function automatic logic [127:0] model(input logic [127:0] d, input logic [7:0] s,
                                         input logic a, input logic n);
    logic [127:0] r;
    logic [31:0]  v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      v = 32'(d >> (32 * int'(s[2*k +: 2])));
`ifdef OPERAND_SPLIT_FTZ_EN
      if (v[30:23] == 8'h00 && v[22:0] != 23'h0) v = v & 32'h8000_0000;
`endif
      if (a) v = v & 32'h7FFF_FFFF;
      if (n) v = v ^ 32'h8000_0000;
      r[32*k +: 32] = v;
    end
    return r;
  endfunction

  // Called at a negedge: reports the output transfer of the coming edge, records
  // the expected result of any input transfer, then advances to the next negedge.
  task automatic tick(output bit fired, output logic [EW-1:0] got);
    fired = out_valid && out_ready;
    got   = {out_tag, out_lane_3, out_lane_2, out_lane_1, out_lane_0};
    if (in_valid && in_ready && !flush && !rst)
      exp_q.push_back({in_tag, model(in_data, in_swizzle, in_abs, in_neg)});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [127:0] d, input logic [7:0] s,
                       input logic a, input logic n, input logic [TW-1:0] t);
    in_valid   = v;
    in_data    = d;
    in_swizzle = s;
    in_abs     = a;
    in_neg     = n;
    in_tag     = t;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, SWZ_IDENTITY, 1'b0, 1'b0, '0);
    @(posedge clk); @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({out_lane_3, out_lane_2, out_lane_1, out_lane_0} !== 128'h0) begin failures++; $display("FAIL reset_lanes got=%h exp=0", {out_lane_3, out_lane_2, out_lane_1, out_lane_0}); end
    checks++; if (out_tag !== '0) begin failures++; $display("FAIL reset_tag got=%h exp=0", out_tag); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_passthrough;
    bit fired; logic [EW-1:0] got, exp;
    out_ready = 1'b1;
    drive(1'b1, {32'h40400000, 32'h40000000, 32'hBF800000, 32'h3F800000}, SWZ_IDENTITY, 1'b0, 1'b0, 6'h15);
    tick(fired, got);
    drive(1'b0, '0, SWZ_IDENTITY, 1'b0, 1'b0, '0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL pass_latency got=%b exp=1", out_valid); end
    checks++; if ({out_lane_3, out_lane_2, out_lane_1, out_lane_0} !== {32'h40400000, 32'h40000000, 32'hBF800000, 32'h3F800000})
      begin failures++; $display("FAIL pass_lanes got=%h", {out_lane_3, out_lane_2, out_lane_1, out_lane_0}); end
    checks++; if (out_tag !== 6'h15) begin failures++; $display("FAIL pass_tag got=%h exp=15", out_tag); end
    tick(fired, got);
    checks++;
    if (!fired || exp_q.size() == 0) begin failures++; $display("FAIL pass_sb fired=%b queued=%0d", fired, exp_q.size()); end
    else begin exp = exp_q.pop_front(); if (got !== exp) begin failures++; $display("FAIL pass_sb got=%h exp=%h", got, exp); end end
  endtask

  task automatic test_swizzle_mods;
    bit fired; logic [EW-1:0] got, exp;
    logic [127:0] d;
    d = {32'h11111111, 32'h22222222, 32'h33333333, 32'hBF800000};
    out_ready = 1'b1;
    for (int m = 0; m < 4; m++) begin
      case (m)
        0: drive(1'b1, d, 8'h00, 1'b1, 1'b0, 6'h21);
        1: drive(1'b1, d, 8'h00, 1'b1, 1'b1, 6'h22);
        2: drive(1'b1, d, 8'h1B, 1'b0, 1'b1, 6'h23);
        default: drive(1'b1, {32'h7FC00001, 32'hFF800000, 32'h80000000, 32'h00000000}, 8'hB1, 1'b1, 1'b1, 6'h24);
      endcase
      tick(fired, got);
      drive(1'b0, '0, SWZ_IDENTITY, 1'b0, 1'b0, '0);
      if (m == 0) begin
        checks++; if ({out_lane_3, out_lane_2, out_lane_1, out_lane_0} !== {4{32'h3F800000}})
          begin failures++; $display("FAIL swz_abs got=%h exp=4x3F800000", {out_lane_3, out_lane_2, out_lane_1, out_lane_0}); end
      end else if (m == 1) begin
        checks++; if ({out_lane_3, out_lane_2, out_lane_1, out_lane_0} !== {4{32'hBF800000}})
          begin failures++; $display("FAIL swz_absneg got=%h exp=4xBF800000", {out_lane_3, out_lane_2, out_lane_1, out_lane_0}); end
      end
      tick(fired, got);
      checks++;
      if (!fired || exp_q.size() == 0) begin failures++; $display("FAIL swz_sb%0d fired=%b queued=%0d", m, fired, exp_q.size()); end
      else begin exp = exp_q.pop_front(); if (got !== exp) begin failures++; $display("FAIL swz_sb%0d got=%h exp=%h", m, got, exp); end end
    end
  endtask

  task automatic test_backpressure;
    bit fired; logic [EW-1:0] got, exp, held;
    int popped;
    out_ready = 1'b0;
    drive(1'b1, {4{32'h01010101}}, SWZ_IDENTITY, 1'b0, 1'b0, 6'd1);
    tick(fired, got);
    drive(1'b1, {4{32'h02020202}}, SWZ_IDENTITY, 1'b0, 1'b0, 6'd2);
    tick(fired, got);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
    drive(1'b1, {4{32'h03030303}}, SWZ_IDENTITY, 1'b0, 1'b0, 6'd3);
    held = {out_tag, out_lane_3, out_lane_2, out_lane_1, out_lane_0};
    for (int i = 0; i < 3; i++) tick(fired, got);
    checks++; if ({out_tag, out_lane_3, out_lane_2, out_lane_1, out_lane_0} !== held || out_valid !== 1'b1)
      begin failures++; $display("FAIL bp_stable got=%h exp=%h", {out_tag, out_lane_3, out_lane_2, out_lane_1, out_lane_0}, held); end
    drive(1'b0, '0, SWZ_IDENTITY, 1'b0, 1'b0, '0);
    out_ready = 1'b1;
    popped = 0;
    for (int i = 0; i < 6; i++) begin
      tick(fired, got);
      if (fired) begin
        checks++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL bp_extra got=%h exp=none", got); end
        else begin
          exp = exp_q.pop_front(); popped++;
          if (got !== exp) begin failures++; $display("FAIL bp_order got=%h exp=%h", got, exp); end
        end
      end
    end
    checks++; if (popped != 2 || exp_q.size() != 0) begin failures++; $display("FAIL bp_count got=%0d exp=2 left=%0d", popped, exp_q.size()); end
  endtask

  task automatic test_back_to_back;
    bit fired; logic [EW-1:0] got, exp;
    int outs;
    out_ready = 1'b1;
    outs = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, {$urandom, $urandom, $urandom, $urandom}, 8'($urandom), 1'($urandom), 1'($urandom), 6'(i + 32));
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=1", i, in_ready); end
      tick(fired, got);
      if (fired) begin
        checks++; outs++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL stream_extra got=%h", got); end
        else begin exp = exp_q.pop_front(); if (got !== exp) begin failures++; $display("FAIL stream_data got=%h exp=%h", got, exp); end end
      end
    end
    drive(1'b0, '0, SWZ_IDENTITY, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      tick(fired, got);
      if (fired) begin
        checks++; outs++;
        if (exp_q.size() == 0) begin failures++; $display("FAIL stream_extra got=%h", got); end
        else begin exp = exp_q.pop_front(); if (got !== exp) begin failures++; $display("FAIL stream_data got=%h exp=%h", got, exp); end end
      end
    end
    checks++; if (outs != 16) begin failures++; $display("FAIL stream_count got=%0d exp=16", outs); end
  endtask

  task automatic test_flush;
    bit fired; logic [EW-1:0] got;
    int late;
    // FULL then flush
    out_ready = 1'b0;
    drive(1'b1, {4{32'hAAAA0001}}, SWZ_IDENTITY, 1'b0, 1'b0, 6'd7);
    tick(fired, got);
    drive(1'b1, {4{32'hAAAA0002}}, SWZ_IDENTITY, 1'b0, 1'b0, 6'd8);
    tick(fired, got);
    flush = 1'b1;
    drive(1'b1, {4{32'hAAAA0003}}, SWZ_IDENTITY, 1'b0, 1'b0, 6'd9);
    tick(fired, got);
    flush = 1'b0;
    exp_q.delete();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_full_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_full_ready got=%b exp=1", in_ready); end
    // ONE then flush with an input offered: the input must vanish too
    drive(1'b1, {4{32'hBBBB0001}}, SWZ_IDENTITY, 1'b0, 1'b0, 6'd10);
    tick(fired, got);
    flush = 1'b1;
    drive(1'b1, {4{32'hBBBB0002}}, SWZ_IDENTITY, 1'b0, 1'b0, 6'd11);
    tick(fired, got);
    flush = 1'b0;
    exp_q.delete();
    drive(1'b0, '0, SWZ_IDENTITY, 1'b0, 1'b0, '0);
    out_ready = 1'b1;
    late = 0;
    for (int i = 0; i < 5; i++) begin
      tick(fired, got);
      if (fired) late++;
    end
    checks++; if (late != 0) begin failures++; $display("FAIL flush_late_out got=%0d exp=0", late); end
  endtask

  task automatic test_async_reset;
    bit fired; logic [EW-1:0] got;
    out_ready = 1'b0;
    drive(1'b1, {4{32'hCCCC0001}}, SWZ_IDENTITY, 1'b0, 1'b0, 6'd12);
    tick(fired, got);
    drive(1'b0, '0, SWZ_IDENTITY, 1'b0, 1'b0, '0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_drop got=%b exp=0", out_valid); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ftz;
    bit fired; logic [EW-1:0] got, exp;
    logic [31:0] want;
`ifdef OPERAND_SPLIT_FTZ_EN
    want = 32'h80000000;
`else
    want = 32'h80000001;
`endif
    out_ready = 1'b1;
    drive(1'b1, {32'h3F800000, 32'h00000000, 32'h007FFFFF, 32'h80000001}, SWZ_IDENTITY, 1'b0, 1'b0, 6'd13);
    tick(fired, got);
    drive(1'b0, '0, SWZ_IDENTITY, 1'b0, 1'b0, '0);
    checks++; if (out_lane_0 !== want) begin failures++; $display("FAIL ftz_lane0 got=%h exp=%h", out_lane_0, want); end
    tick(fired, got);
    checks++;
    if (!fired || exp_q.size() == 0) begin failures++; $display("FAIL ftz_sb fired=%b queued=%0d", fired, exp_q.size()); end
    else begin exp = exp_q.pop_front(); if (got !== exp) begin failures++; $display("FAIL ftz_sb got=%h exp=%h", got, exp); end end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_swizzle_mods();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_ftz();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_split.md
Name: operand_split

Overview:
- Read-side counterpart of the writeback merge stage.
- Takes a 128-bit vector register read from the register file and splits it into four 32-bit FP32 lane operands (lane 0 = bits 31:0 … lane 3 = bits 127:96).
- Applies a per-instruction swizzle and abs/neg source modifiers.
- Delivers the lanes to the execute stage through a valid/ready pipeline register with a skid buffer.

Parameters:
- TAG_W, 6, width of the instruction tag carried alongside the operands.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous pipeline flush; kills buffered operands
- in_valid  in  1  RF read data valid
- in_ready  out  1  stage can accept a read this cycle
- in_data  in  128  RF read data
- in_swizzle  in  8  per-lane source select; bits [2k+1:2k] select the source lane for output lane k
- in_abs  in  1  clear sign bit of all lanes
- in_neg  in  1  invert sign bit of all lanes (applied after abs)
- in_tag  in  TAG_W  instruction tag
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts operands
- out_lane_0..out_lane_3  out  32 each  processed lane operands
- out_tag  out  TAG_W  tag of the presented operands

Behaviour:
- Reset (async, rst=1):
  - out_valid=0; skid_valid=0, so in_ready=1.
  - out_lane_0..3 = 32'd0; out_tag = 0.
- Transform is combinational on the input side, before registering:
  - lane_k = src_lane[in_swizzle[2k+1:2k]]
  - if in_abs: bit31 = 0
  - then if in_neg: bit31 = ~bit31
  - Identity swizzle = 8'hE4.
  - Only bit 31 is altered; exponent and mantissa pass unchanged. NaN operands receive the same sign handling.
- Latency: 1 cycle. An input accepted at edge N appears on the outputs after edge N.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_ready = ~skid_valid, a registered term with no combinational path from out_ready.
- Storage: main output register (out_*) plus one skid register. State is encoded by {out_valid, skid_valid}: EMPTY (0,0), ONE (1,0), FULL (1,1).
- State transitions:
  - EMPTY: input accepted → ONE, data loaded into the output register.
  - ONE, input accepted and output taken → ONE, new data in the output register.
  - ONE, input accepted and output not taken → FULL, new data in skid.
  - ONE, output taken and no input → EMPTY.
  - FULL, output taken → ONE, skid moves to output. in_ready=0, so no input is accepted in this cycle.
  - FULL, output not taken → hold. All out_* stay stable while out_valid & ~out_ready.
- Order: strict FIFO; the tag always travels with its lanes.
- flush:
  - Next edge: out_valid=0, skid_valid=0.
  - An input presented in the flush cycle is discarded.
  - Lane and tag registers are not cleared.
  - flush has priority over all transfers.
- Reset mid-transfer: all buffered operands are lost; out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: OPERAND_SPLIT_FTZ_EN.
- Defined: after swizzle and before abs/neg, any lane with exponent==0 and mantissa!=0 is flushed to signed zero (sign kept, bits 30:0 = 0).
- Undefined: denormals pass unchanged; no extra logic.

Decomposition:
- Shared package gpu_operand_pkg:
  - LANES=4, LANE_W=32, VEC_W=128
  - SWZ_IDENTITY=8'hE4
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23
  - packed lane-vector typedef
- One natural sub-module: operand_lane_mod. Single-lane combinational transform (FTZ, abs, neg), instantiated four times after the swizzle mux.

Test Plan:
- Pass-through: in_data={32'h40400000,32'h40000000,32'hBF800000,32'h3F800000}, swizzle=E4, abs=neg=0, out_ready=1 → one cycle later lanes 0..3 = 3F800000, BF800000, 40000000, 40400000; tag preserved.
- Swizzle/modifiers:
  - swizzle=8'h00 with lane0=BF800000, abs=1 → all four lanes 3F800000.
  - Same with abs=1, neg=1 → all four lanes BF800000.
- Backpressure:
  - out_ready=0, push tags 1, 2 → state FULL, in_ready=0; a third in_valid is not accepted.
  - Raise out_ready → tags emerge 1 then 2, with no loss or duplication and outputs stable while stalled.
- Streaming: out_ready=1, in_valid held high for 16 cycles → 16 transfers back to back, in_ready constantly 1.
- Flush/reset:
  - FULL state, pulse flush with in_valid=1 → next cycle out_valid=0, in_ready=1, nothing emitted later.
  - Assert rst between edges → out_valid drops immediately.
- FTZ (macro defined): lane=32'h80000001 → 32'h80000000. Macro undefined → 32'h80000001 unchanged.
